// File: rtl/cfg_access_arbiter_if.sv
// cfg_access_arbiter_if: requester and config-space (CS) Avalon-MM bus bundle
// Names keep their _i/_o suffix as seen from the arbiter.
// The slave modport is the arbiter's view; master is the requesters plus the CS slave.
interface cfg_access_arbiter_if #(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 32,
    parameter int RESP_WIDTH = 2
);
    logic [NUM_REQ-1:0]            req_read_i;
    logic [NUM_REQ-1:0]            req_write_i;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_address_i;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_writedata_i;
    logic [NUM_REQ-1:0]            req_waitrequest_o;
    logic [NUM_REQ-1:0]            req_readdatavalid_o;
    logic [NUM_REQ-1:0]            req_writerespvalid_o;
    logic [DATA_WIDTH-1:0]         req_readdata_o;
    logic [RESP_WIDTH-1:0]         req_resp_o;
    logic                          cs_read_o;
    logic                          cs_write_o;
    logic [ADDR_WIDTH-1:0]         cs_address_o;
    logic [DATA_WIDTH-1:0]         cs_writedata_o;
    logic                          cs_waitrequest_i;
    logic                          cs_readdatavalid_i;
    logic                          cs_writerespvalid_i;
    logic [DATA_WIDTH-1:0]         cs_readdata_i;
    logic [RESP_WIDTH-1:0]         cs_resp_i;

    modport slave (
        input  req_read_i, req_write_i, req_address_i, req_writedata_i,
        input  cs_waitrequest_i, cs_readdatavalid_i, cs_writerespvalid_i, cs_readdata_i, cs_resp_i,
        output req_waitrequest_o, req_readdatavalid_o, req_writerespvalid_o, req_readdata_o, req_resp_o,
        output cs_read_o, cs_write_o, cs_address_o, cs_writedata_o
    );

    modport master (
        output req_read_i, req_write_i, req_address_i, req_writedata_i,
        output cs_waitrequest_i, cs_readdatavalid_i, cs_writerespvalid_i, cs_readdata_i, cs_resp_i,
        input  req_waitrequest_o, req_readdatavalid_o, req_writerespvalid_o, req_readdata_o, req_resp_o,
        input  cs_read_o, cs_write_o, cs_address_o, cs_writedata_o
    );
endinterface

// File: rtl/cfg_access_arbiter.sv
// cfg_access_arbiter: round-robin sharing of the config-space Avalon-MM slave, one transaction in flight
// Optional response timeout is enabled by defining CFG_ARB_TIMEOUT_EN.
module cfg_access_arbiter #(
    parameter int                    NUM_REQ     = 2,
    parameter int                    ADDR_WIDTH  = 14,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    RESP_WIDTH  = 2,
    parameter logic [RESP_WIDTH-1:0] SLAVE_ERROR = 2'b10,
    parameter int unsigned           TIMEOUT_CYC = 5000000
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    cfg_access_arbiter_if.slave        bus,
    output logic                       busy_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_o,
    output logic [15:0]                timeout_cnt_o
);
    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;

    state_t                r_state, w_next;
    logic [GW-1:0]         r_ptr, r_grant, w_pick;
    logic                  w_any, w_hit, w_to, w_done, r_is_rd;
    logic [NUM_REQ-1:0]    w_pend, w_onehot, r_rdv, r_wrv;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata, r_rdata;
    logic [RESP_WIDTH-1:0] r_resp;

    assign w_pend   = bus.req_read_i | bus.req_write_i;
    assign w_onehot = NUM_REQ'(1) << r_grant;
    assign w_hit    = (r_state == WAIT_RSP) && (r_is_rd ? bus.cs_readdatavalid_i : bus.cs_writerespvalid_i);
    assign w_done   = w_hit | w_to;

`ifdef CFG_ARB_TIMEOUT_EN
    logic [31:0] r_wait_cnt;
    logic [15:0] r_to_cnt;

    // A response in the limit cycle wins over the timeout
    assign w_to = (r_state == WAIT_RSP) && !w_hit && (r_wait_cnt == 32'(TIMEOUT_CYC - 1));
    assign timeout_cnt_o = r_to_cnt;

    // WAIT_RSP cycle counter (zero on entry) and saturating timeout tally
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wait_cnt <= '0;
            r_to_cnt   <= '0;
        end else begin
            r_wait_cnt <= (r_state == WAIT_RSP) ? r_wait_cnt + 32'd1 : '0;
            r_to_cnt   <= (w_to && r_to_cnt != 16'hFFFF) ? r_to_cnt + 16'd1 : r_to_cnt;
        end
    end
`else
    logic w_unused;

    assign w_to          = 1'b0;
    assign timeout_cnt_o = '0;
    assign w_unused      = ^TIMEOUT_CYC;
`endif

    // Round robin: first pending master at or after the pointer (lowest offset wins)
    always_comb begin
        w_any  = 1'b0;
        w_pick = r_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (w_pend[GW'((int'(r_ptr) + k) % NUM_REQ)]) begin
                w_any  = 1'b1;
                w_pick = GW'((int'(r_ptr) + k) % NUM_REQ);
            end
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        r_state <= rst_i ? IDLE : w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     w_next = w_any ? ISSUE : IDLE;
            ISSUE:    w_next = bus.cs_waitrequest_i ? ISSUE : WAIT_RSP;
            WAIT_RSP: w_next = w_done ? IDLE : WAIT_RSP;
            default:  w_next = IDLE;
        endcase
    end

    // Command and handshake outputs; only the granted master can see waitrequest low
    always_comb begin
        busy_o                = r_state != IDLE;
        bus.cs_read_o         = (r_state == ISSUE) && r_is_rd;
        bus.cs_write_o        = (r_state == ISSUE) && !r_is_rd;
        bus.req_waitrequest_o = (r_state == ISSUE && !bus.cs_waitrequest_i) ? ~w_onehot : '1;
    end

    // Grant capture and registered response routing; response fields read zero between pulses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ptr   <= '0;
            r_grant <= '0;
            r_is_rd <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdv   <= '0;
            r_wrv   <= '0;
            r_rdata <= '0;
            r_resp  <= '0;
        end else begin
            if (r_state == IDLE && w_any) begin
                r_grant <= w_pick;
                r_ptr   <= (w_pick == GW'(NUM_REQ - 1)) ? '0 : w_pick + 1'b1;
                r_is_rd <= bus.req_read_i[w_pick];
                r_addr  <= bus.req_address_i[w_pick*ADDR_WIDTH +: ADDR_WIDTH];
                r_wdata <= bus.req_writedata_i[w_pick*DATA_WIDTH +: DATA_WIDTH];
            end
            r_rdv   <= (w_done && r_is_rd) ? w_onehot : '0;
            r_wrv   <= (w_done && !r_is_rd) ? w_onehot : '0;
            r_rdata <= w_hit ? bus.cs_readdata_i : (w_to ? '1 : '0);
            r_resp  <= w_hit ? bus.cs_resp_i : (w_to ? SLAVE_ERROR : '0);
        end
    end

    assign grant_o                  = r_grant;
    assign bus.cs_address_o         = r_addr;
    assign bus.cs_writedata_o       = r_wdata;
    assign bus.req_readdatavalid_o  = r_rdv;
    assign bus.req_writerespvalid_o = r_wrv;
    assign bus.req_readdata_o       = r_rdata;
    assign bus.req_resp_o           = r_resp;
endmodule

// File: tb/tb_cfg_access_arbiter.sv
// tb_cfg_access_arbiter: directed self-checking bench for cfg_access_arbiter (NUM_REQ=2, TIMEOUT_CYC=16)
module tb_cfg_access_arbiter;
    localparam int NR = 2;
    localparam int AW = 14;
    localparam int DW = 32;
    localparam int RW = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy;
    logic [0:0]  grant;
    logic [15:0] tcnt;
    int          errors = 0;
    int          checks = 0;

    cfg_access_arbiter_if #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESP_WIDTH(RW)) bus ();

    cfg_access_arbiter #(
        .NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESP_WIDTH(RW),
        .SLAVE_ERROR(2'b10), .TIMEOUT_CYC(16)
    ) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus),
        .busy_o(busy), .grant_o(grant), .timeout_cnt_o(tcnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%0h exp=0", busy); end
        checks++; if (bus.req_waitrequest_o !== 2'b11) begin errors++; $display("FAIL rst_waitreq got=%b exp=11", bus.req_waitrequest_o); end
        checks++; if ({bus.req_readdatavalid_o, bus.req_writerespvalid_o} !== 4'b0) begin errors++; $display("FAIL rst_valids got=%b exp=0000", {bus.req_readdatavalid_o, bus.req_writerespvalid_o}); end
        checks++; if ({bus.cs_read_o, bus.cs_write_o} !== 2'b00) begin errors++; $display("FAIL rst_cmd got=%b exp=00", {bus.cs_read_o, bus.cs_write_o}); end
        checks++; if ({bus.req_readdata_o, bus.req_resp_o, bus.cs_address_o, bus.cs_writedata_o} !== '0) begin errors++; $display("FAIL rst_data got nonzero data/resp/addr"); end
        checks++; if ({grant, tcnt} !== 17'b0) begin errors++; $display("FAIL rst_grant_tcnt got=%0h/%0h exp=0/0", grant, tcnt); end
        rst = 1'b0;
    endtask

    task automatic test_single_read;
        @(negedge clk);
        bus.req_read_i = 2'b01;
        bus.req_address_i = {14'h0, 14'h0010};
        bus.cs_waitrequest_i = 1'b0;
        @(negedge clk);
        checks++; if ({busy, bus.cs_read_o, bus.cs_write_o} !== 3'b110) begin errors++; $display("FAIL sr_issue got=%b exp=110", {busy, bus.cs_read_o, bus.cs_write_o}); end
        checks++; if (bus.cs_address_o !== 14'h0010) begin errors++; $display("FAIL sr_addr got=%h exp=0010", bus.cs_address_o); end
        checks++; if (bus.req_waitrequest_o !== 2'b10 || grant !== 1'b0) begin errors++; $display("FAIL sr_waitreq got=%b g=%0d exp=10 g=0", bus.req_waitrequest_o, grant); end
        @(negedge clk);
        bus.req_read_i = 2'b00;
        checks++; if ({busy, bus.cs_read_o, bus.req_waitrequest_o} !== 4'b1011) begin errors++; $display("FAIL sr_wait got=%b exp=1011", {busy, bus.cs_read_o, bus.req_waitrequest_o}); end
        bus.cs_writerespvalid_i = 1'b1;
        @(negedge clk);
        bus.cs_writerespvalid_i = 1'b0;
        checks++; if ({busy, bus.req_readdatavalid_o, bus.req_writerespvalid_o} !== 5'b10000) begin errors++; $display("FAIL sr_wrong_strobe got=%b exp=10000", {busy, bus.req_readdatavalid_o, bus.req_writerespvalid_o}); end
        @(negedge clk);
        bus.cs_readdatavalid_i = 1'b1;
        bus.cs_readdata_i = 32'hCAFE_0001;
        bus.cs_resp_i = 2'b00;
        @(negedge clk);
        bus.cs_readdatavalid_i = 1'b0;
        checks++; if (bus.req_readdatavalid_o !== 2'b01 || bus.req_writerespvalid_o !== 2'b00) begin errors++; $display("FAIL sr_rdv got=%b/%b exp=01/00", bus.req_readdatavalid_o, bus.req_writerespvalid_o); end
        checks++; if (bus.req_readdata_o !== 32'hCAFE_0001 || bus.req_resp_o !== 2'b00) begin errors++; $display("FAIL sr_rdata got=%h/%b exp=cafe0001/00", bus.req_readdata_o, bus.req_resp_o); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sr_busy_end got=%0h exp=0", busy); end
        @(negedge clk);
        checks++; if (bus.req_readdatavalid_o !== 2'b00 || bus.req_readdata_o !== 32'h0) begin errors++; $display("FAIL sr_clear got=%b/%h exp=00/0", bus.req_readdatavalid_o, bus.req_readdata_o); end
    endtask

    task automatic test_round_robin;
        int   gseq[$];
        int   pulses[2];
        int   rdvs[2];
        int   alt_bad;
        logic resp_next;
        pulses = '{0, 0};
        rdvs = '{0, 0};
        alt_bad = 0;
        resp_next = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.req_read_i = 2'b11;
        bus.req_address_i = {14'h0B00, 14'h0A00};
        bus.cs_waitrequest_i = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            bus.cs_readdatavalid_i = resp_next;
            bus.cs_readdata_i = 32'(c);
            resp_next = 1'b0;
            if (c == 30) bus.req_read_i = 2'b00;
            for (int k = 0; k < 2; k++) begin
                if (!bus.req_waitrequest_o[k]) pulses[k]++;
                if (bus.req_readdatavalid_o[k]) rdvs[k]++;
            end
            if (bus.req_waitrequest_o !== 2'b11) begin
                gseq.push_back(int'(grant));
                resp_next = 1'b1;
                checks++; if (bus.req_waitrequest_o !== ~(2'b01 << grant)) begin errors++; $display("FAIL rr_pulse_owner got=%b grant=%0d", bus.req_waitrequest_o, grant); end
            end
        end
        foreach (gseq[i]) if (gseq[i] != i % 2) alt_bad++;
        checks++; if (gseq.size() < 4 || alt_bad != 0) begin errors++; $display("FAIL rr_alternate got n=%0d bad=%0d exp n>=4 bad=0", gseq.size(), alt_bad); end
        checks++; if (pulses[0] != rdvs[0] || pulses[1] != rdvs[1]) begin errors++; $display("FAIL rr_one_pulse_per_txn got p=%0d/%0d r=%0d/%0d", pulses[0], pulses[1], rdvs[0], rdvs[1]); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_idle_end got=%0h exp=0", busy); end
    endtask

    task automatic test_backpressure;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.req_write_i = 2'b01;
        bus.req_read_i = 2'b10;
        bus.req_writedata_i = {32'hDEAD_BEEF, 32'h1234_5678};
        bus.req_address_i = {14'h0000, 14'h0022};
        bus.cs_waitrequest_i = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 6) begin
                bus.cs_waitrequest_i = 1'b0;
                #1;
            end
            checks++; if ({bus.cs_write_o, bus.cs_read_o, bus.cs_writedata_o, bus.cs_address_o} !== {2'b10, 32'h1234_5678, 14'h0022}) begin errors++; $display("FAIL bp_cmd_stable c=%0d got w=%b d=%h a=%h", c, bus.cs_write_o, bus.cs_writedata_o, bus.cs_address_o); end
            checks++; if (bus.req_waitrequest_o !== ((c == 6) ? 2'b10 : 2'b11)) begin errors++; $display("FAIL bp_waitreq c=%0d got=%b", c, bus.req_waitrequest_o); end
        end
        @(negedge clk);
        bus.req_write_i = 2'b00;
        checks++; if ({busy, bus.cs_write_o} !== 2'b10) begin errors++; $display("FAIL bp_dropped got=%b exp=10", {busy, bus.cs_write_o}); end
        bus.cs_writerespvalid_i = 1'b1;
        bus.cs_resp_i = 2'b01;
        @(negedge clk);
        bus.cs_writerespvalid_i = 1'b0;
        checks++; if ({bus.req_writerespvalid_o, bus.req_readdatavalid_o, bus.req_resp_o} !== 6'b010001) begin errors++; $display("FAIL bp_wresp got=%b exp=010001", {bus.req_writerespvalid_o, bus.req_readdatavalid_o, bus.req_resp_o}); end
        @(negedge clk);
        checks++; if (grant !== 1'b1 || bus.cs_read_o !== 1'b1 || bus.req_waitrequest_o !== 2'b01) begin errors++; $display("FAIL bp_m1_grant got g=%0d rd=%b wr=%b", grant, bus.cs_read_o, bus.req_waitrequest_o); end
        @(negedge clk);
        bus.req_read_i = 2'b00;
        bus.cs_readdatavalid_i = 1'b1;
        bus.cs_readdata_i = 32'hBEEF_0001;
        bus.cs_resp_i = 2'b00;
        @(negedge clk);
        bus.cs_readdatavalid_i = 1'b0;
        checks++; if (bus.req_readdatavalid_o !== 2'b10 || bus.req_readdata_o !== 32'hBEEF_0001) begin errors++; $display("FAIL bp_m1_rdv got=%b/%h exp=10/beef0001", bus.req_readdatavalid_o, bus.req_readdata_o); end
    endtask

    task automatic test_timeout;
`ifdef CFG_ARB_TIMEOUT_EN
        int n;
        @(negedge clk);
        bus.req_read_i = 2'b01;
        bus.req_address_i = {14'h0, 14'h0030};
        bus.cs_waitrequest_i = 1'b0;
        @(negedge clk);
        checks++; if (bus.req_waitrequest_o !== 2'b10) begin errors++; $display("FAIL to_issue got=%b exp=10", bus.req_waitrequest_o); end
        @(negedge clk);
        bus.req_read_i = 2'b00;
        n = 2;
        while (n < 40 && bus.req_readdatavalid_o === 2'b00) begin
            @(negedge clk);
            n++;
        end
        checks++; if (n != 18) begin errors++; $display("FAIL to_latency got=%0d exp=18", n); end
        checks++; if (bus.req_readdatavalid_o !== 2'b01 || bus.req_readdata_o !== 32'hFFFF_FFFF || bus.req_resp_o !== 2'b10) begin errors++; $display("FAIL to_resp got=%b/%h/%b exp=01/ffffffff/10", bus.req_readdatavalid_o, bus.req_readdata_o, bus.req_resp_o); end
        checks++; if (tcnt !== 16'd1 || busy !== 1'b0) begin errors++; $display("FAIL to_count got=%0d busy=%0h exp=1 busy=0", tcnt, busy); end
        bus.cs_readdatavalid_i = 1'b1;
        bus.cs_readdata_i = 32'h5555_5555;
        @(negedge clk);
        bus.cs_readdatavalid_i = 1'b0;
        checks++; if ({busy, bus.req_readdatavalid_o, bus.req_readdata_o} !== 35'b0) begin errors++; $display("FAIL to_late_strobe got rdv=%b d=%h", bus.req_readdatavalid_o, bus.req_readdata_o); end
        bus.req_read_i = 2'b10;
        bus.req_address_i = {14'h0031, 14'h0};
        @(negedge clk);
        checks++; if (bus.req_waitrequest_o !== 2'b01) begin errors++; $display("FAIL to_edge_issue got=%b exp=01", bus.req_waitrequest_o); end
        @(negedge clk);
        bus.req_read_i = 2'b00;
        repeat (15) @(negedge clk);
        checks++; if (bus.req_readdatavalid_o !== 2'b00 || busy !== 1'b1) begin errors++; $display("FAIL to_edge_early got=%b busy=%0h", bus.req_readdatavalid_o, busy); end
        bus.cs_readdatavalid_i = 1'b1;
        bus.cs_readdata_i = 32'h0000_AAAA;
        bus.cs_resp_i = 2'b00;
        @(negedge clk);
        bus.cs_readdatavalid_i = 1'b0;
        checks++; if (bus.req_readdatavalid_o !== 2'b10 || bus.req_readdata_o !== 32'h0000_AAAA || bus.req_resp_o !== 2'b00 || tcnt !== 16'd1) begin errors++; $display("FAIL to_edge_wins got=%b/%h/%b cnt=%0d exp=10/0000aaaa/00 cnt=1", bus.req_readdatavalid_o, bus.req_readdata_o, bus.req_resp_o, tcnt); end
`else
        @(negedge clk);
        bus.req_read_i = 2'b01;
        bus.req_address_i = {14'h0, 14'h0030};
        bus.cs_waitrequest_i = 1'b0;
        repeat (2) @(negedge clk);
        bus.req_read_i = 2'b00;
        repeat (30) @(negedge clk);
        checks++; if (bus.req_readdatavalid_o !== 2'b00 || busy !== 1'b1 || tcnt !== 16'd0) begin errors++; $display("FAIL nto_waits got=%b busy=%0h cnt=%0d", bus.req_readdatavalid_o, busy, tcnt); end
        bus.cs_readdatavalid_i = 1'b1;
        bus.cs_readdata_i = 32'h0000_0042;
        @(negedge clk);
        bus.cs_readdatavalid_i = 1'b0;
        checks++; if (bus.req_readdatavalid_o !== 2'b01 || bus.req_readdata_o !== 32'h0000_0042) begin errors++; $display("FAIL nto_resp got=%b/%h exp=01/00000042", bus.req_readdatavalid_o, bus.req_readdata_o); end
`endif
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        bus.req_read_i = 2'b01;
        bus.req_address_i = {14'h0, 14'h0040};
        bus.cs_waitrequest_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        bus.req_read_i = 2'b00;
        checks++; if (busy !== 1'b1 || bus.cs_read_o !== 1'b0) begin errors++; $display("FAIL rm_in_wait got busy=%0h rd=%b", busy, bus.cs_read_o); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if ({busy, bus.cs_read_o, bus.cs_write_o, bus.req_readdatavalid_o, bus.req_writerespvalid_o} !== 7'b0 || bus.req_waitrequest_o !== 2'b11) begin errors++; $display("FAIL rm_outputs got busy=%0h wr=%b", busy, bus.req_waitrequest_o); end
        checks++; if ({grant, tcnt, bus.cs_address_o, bus.req_readdata_o} !== '0) begin errors++; $display("FAIL rm_regs got g=%0d cnt=%0d a=%h", grant, tcnt, bus.cs_address_o); end
        bus.cs_readdatavalid_i = 1'b1;
        bus.cs_readdata_i = 32'h0000_0077;
        @(negedge clk);
        bus.cs_readdatavalid_i = 1'b0;
        checks++; if ({busy, bus.req_readdatavalid_o, bus.req_readdata_o} !== 35'b0) begin errors++; $display("FAIL rm_late_drop got rdv=%b d=%h", bus.req_readdatavalid_o, bus.req_readdata_o); end
        bus.req_read_i = 2'b11;
        @(negedge clk);
        checks++; if (grant !== 1'b0 || bus.req_waitrequest_o !== 2'b10) begin errors++; $display("FAIL rm_ptr_restart got g=%0d wr=%b exp=0/10", grant, bus.req_waitrequest_o); end
        bus.req_read_i = 2'b00;
        @(negedge clk);
        bus.cs_readdatavalid_i = 1'b1;
        bus.cs_readdata_i = 32'h0000_0099;
        @(negedge clk);
        bus.cs_readdatavalid_i = 1'b0;
        checks++; if (bus.req_readdatavalid_o !== 2'b01 || bus.req_readdata_o !== 32'h0000_0099) begin errors++; $display("FAIL rm_after got=%b/%h exp=01/00000099", bus.req_readdatavalid_o, bus.req_readdata_o); end
    endtask

    initial begin
        bus.req_read_i = '0;
        bus.req_write_i = '0;
        bus.req_address_i = '0;
        bus.req_writedata_i = '0;
        bus.cs_waitrequest_i = 1'b0;
        bus.cs_readdatavalid_i = 1'b0;
        bus.cs_writerespvalid_i = 1'b0;
        bus.cs_readdata_i = '0;
        bus.cs_resp_i = '0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
